// File: rtl/rm_pkg.sv
// Shared types and constants for the Avalon-MM read master.
package rm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } rm_state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [31:0] ADDR_INC   = 32'(WORD_BYTES);

endpackage

// File: rtl/read_master_if.sv
// Avalon-MM read-only bus between the read master and its slave.
interface read_master_if;

  logic        oRM_read;
  logic [31:0] oRM_readaddress;
  logic [31:0] iRM_readdata;
  logic        iRM_waitrequest;
  logic        iRM_readdatavalid;

  modport master (
    output oRM_read,
    output oRM_readaddress,
    input  iRM_readdata,
    input  iRM_waitrequest,
    input  iRM_readdatavalid
  );

  modport slave (
    input  oRM_read,
    input  oRM_readaddress,
    output iRM_readdata,
    output iRM_waitrequest,
    output iRM_readdatavalid
  );

endinterface

// File: rtl/rm_credit_counter.sv
// Outstanding-read counter plus FIFO credit check for the read master.
module rm_credit_counter #(
  parameter int MAX_PENDING = 4,
  parameter int FF_DEPTH    = 16,
  parameter int FF_USEDW_W  = 5,
  localparam int CNT_W      = $clog2(MAX_PENDING + 1)
) (
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic                  clr,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  ff_write,
  input  logic [FF_USEDW_W-1:0] ff_usedw,
  output logic [CNT_W-1:0]      count,
  output logic                  dec_ok,
  output logic                  credit_ok
);

  logic [CNT_W-1:0] count_nxt;
  logic [31:0]      fill_proj;

  // A response with nothing outstanding is stale (e.g. issued before a reset).
  assign dec_ok = dec && (count != '0);

  always_comb begin
    count_nxt = count;
    if (inc && !dec_ok)      count_nxt = count + CNT_W'(1);
    else if (!inc && dec_ok) count_nxt = count - CNT_W'(1);
  end

  // Credit is judged on next-cycle values, because the read strobe is registered:
  // words already pushed, the push now in the output register, the push this
  // response will cause, and reads still in flight.
  always_comb begin
    fill_proj = 32'(ff_usedw) + 32'(count_nxt) + 32'(ff_write) + 32'(dec_ok);
    credit_ok = (32'(count_nxt) < 32'(MAX_PENDING)) && (fill_proj < 32'(FF_DEPTH));
  end

  always_ff @(posedge iClk) begin
    if (iReset || clr) count <= '0;
    else               count <= count_nxt;
  end

endmodule

// File: rtl/read_master.sv
// Avalon-MM burst-less read master: streams Length bytes from memory into a
// downstream FIFO, never issuing more reads than the FIFO can absorb.
module read_master
  import rm_pkg::*;
#(
  parameter int MAX_PENDING = 4,
  parameter int FF_DEPTH    = 16,
  parameter int FF_USEDW_W  = 5
) (
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic                  Start,
  input  logic [31:0]           Length,
  input  logic [31:0]           RM_startaddress,
  input  logic [FF_USEDW_W-1:0] FF_usedw,
  output logic                  FF_write,
  output logic [31:0]           FF_data,
  read_master_if.master         rm,
  output logic                  RM_busy,
  output logic                  RM_done
);

  localparam int CNT_W = $clog2(MAX_PENDING + 1);

  rm_state_e        state;
  logic             rd;
  logic [31:0]      addr;
  logic [29:0]      words_left;
  logic [CNT_W-1:0] pending;
  logic             accept;
  logic             clr;
  logic             credit_ok;
  logic             dec_ok;
  logic             unused_len_lsbs;

  assign accept             = rd && !rm.iRM_waitrequest;
  assign clr                = (state == IDLE) && Start;
  assign rm.oRM_read        = rd;
  assign rm.oRM_readaddress = addr;
  assign unused_len_lsbs    = ^Length[1:0];

  rm_credit_counter #(
    .MAX_PENDING (MAX_PENDING),
    .FF_DEPTH    (FF_DEPTH),
    .FF_USEDW_W  (FF_USEDW_W)
  ) u_credit (
    .iClk      (iClk),
    .iReset    (iReset),
    .clr       (clr),
    .inc       (accept),
    .dec       (rm.iRM_readdatavalid),
    .ff_write  (FF_write),
    .ff_usedw  (FF_usedw),
    .count     (pending),
    .dec_ok    (dec_ok),
    .credit_ok (credit_ok)
  );

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state      <= IDLE;
      rd         <= 1'b0;
      addr       <= '0;
      words_left <= '0;
      FF_write   <= 1'b0;
      FF_data    <= '0;
      RM_busy    <= 1'b0;
      RM_done    <= 1'b0;
    end else begin
      FF_write <= dec_ok;
      if (dec_ok) FF_data <= rm.iRM_readdata;
      RM_done <= 1'b0;

      case (state)
        IDLE: begin
          if (Start) begin
            words_left <= Length[31:2];
            addr       <= RM_startaddress;
            RM_busy    <= 1'b1;
            state      <= (Length[31:2] == '0) ? DONE : ISSUE;
          end
        end

        ISSUE: begin
          // A raised request is held untouched until the slave takes it.
          if (!rd) begin
            rd <= credit_ok && (words_left != '0);
          end else if (accept) begin
            addr       <= addr + ADDR_INC;
            words_left <= words_left - 30'd1;
            if (words_left == 30'd1) begin
              rd    <= 1'b0;
              state <= DRAIN;
            end else begin
              rd <= credit_ok;
            end
          end
        end

        DRAIN: begin
          if (pending == '0 && !FF_write) state <= DONE;
        end

        DONE: begin
          RM_done <= 1'b1;
          RM_busy <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
